ins_encoder: RTL and testbench

INS_ENCODER -- requirements
Module: ins_encoder

---
 rtl/ins_encoder.sv | 145 ++++++++++++++
 tb/tb_ins_encoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_encoder.sv
// ins_encoder: packs instruction fields into 32-bit words and queues them in a DEPTH-entry FIFO.
// Optional immediate range checking is compiled in when INS_ENCODER_RANGECHK_EN is defined.
module ins_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             INS_ENCODER_CLOCK_50,
    input  logic             INS_ENCODER_RESET_InHigh,
    input  logic             INS_ENCODER_Valid_In,
    output logic             INS_ENCODER_Ready_Out,
    input  logic [2:0]       INS_ENCODER_Fmt_InBUS,
    input  logic [6:0]       INS_ENCODER_Opcode_InBUS,
    input  logic [2:0]       INS_ENCODER_Funct3_InBUS,
    input  logic [4:0]       INS_ENCODER_Rd_InBUS,
    input  logic [4:0]       INS_ENCODER_Rs1_InBUS,
    input  logic [4:0]       INS_ENCODER_Rs2_InBUS,
    input  logic [31:0]      INS_ENCODER_Imm_InBUS,
    output logic             INS_ENCODER_Valid_Out,
    input  logic             INS_ENCODER_Ready_In,
    output logic [31:0]      INS_ENCODER_ins_OutBUS,
    output logic             INS_ENCODER_Err_Out,
    input  logic             INS_ENCODER_ErrClr_In,
    output logic [CNT_W-1:0] INS_ENCODER_Count_OutBUS
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic [CNT_W-1:0] cnt;
    logic             err;

    logic [31:0] word;
    logic        fmt_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        err_set;

    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign imm = INS_ENCODER_Imm_InBUS;
    assign op  = INS_ENCODER_Opcode_InBUS;
    assign f3  = INS_ENCODER_Funct3_InBUS;
    assign rd  = INS_ENCODER_Rd_InBUS;
    assign rs1 = INS_ENCODER_Rs1_InBUS;
    assign rs2 = INS_ENCODER_Rs2_InBUS;

    always_comb begin
        word   = '0;
        fmt_ok = 1'b1;
        case (INS_ENCODER_Fmt_InBUS)
            FMT_I:   word = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   word = {imm[31:12], rd, op};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: fmt_ok = 1'b0;
        endcase
    end

    // Full blocks acceptance outright, even when a pop frees a slot this cycle.
    assign INS_ENCODER_Ready_Out = (occ != FULL_OCC);
    assign INS_ENCODER_Valid_Out = (occ != '0);
    assign accept = INS_ENCODER_Valid_In && INS_ENCODER_Ready_Out && !INS_ENCODER_RESET_InHigh;
    assign push   = accept && fmt_ok;
    assign pop    = INS_ENCODER_Valid_Out && INS_ENCODER_Ready_In;

`ifdef INS_ENCODER_RANGECHK_EN
    logic range_bad;

    // Each range is a signed field width, so checking sign-extension of the upper bits suffices.
    always_comb begin
        range_bad = 1'b0;
        case (INS_ENCODER_Fmt_InBUS)
            FMT_I, FMT_S: range_bad = (imm[31:11] != {21{imm[11]}});
            FMT_B:        range_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_U:        range_bad = (imm[11:0] != '0);
            FMT_J:        range_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            default:      range_bad = 1'b0;
        endcase
    end

    assign err_set = accept && (!fmt_ok || range_bad);
`else
    assign err_set = accept && !fmt_ok;
`endif

    always_ff @(posedge INS_ENCODER_CLOCK_50) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge INS_ENCODER_CLOCK_50) begin
        if (INS_ENCODER_RESET_InHigh) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (push && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (INS_ENCODER_ErrClr_In) begin
                err <= 1'b0;
            end
        end
    end

    assign INS_ENCODER_ins_OutBUS   = INS_ENCODER_Valid_Out ? mem[rd_ptr] : '0;
    assign INS_ENCODER_Err_Out      = err;
    assign INS_ENCODER_Count_OutBUS = cnt;

endmodule

// File: tb/tb_ins_encoder.sv
// tb_ins_encoder: directed and randomized checks of ins_encoder against a queue-based reference model.
// Build with or without INS_ENCODER_RANGECHK_EN; the model follows the same macro.
module tb_ins_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             vin;
    logic             rdy_out;
    logic [2:0]       fmt;
    logic [6:0]       op;
    logic [2:0]       f3;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic             vout;
    logic             rdy_in;
    logic [31:0]      word;
    logic             err;
    logic             eclr;
    logic [CNT_W-1:0] cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    bit          m_err;
    int          m_pushes;
    bit          last_acc;

    always #5 clk = ~clk;

    ins_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .INS_ENCODER_CLOCK_50     (clk),
        .INS_ENCODER_RESET_InHigh (rst),
        .INS_ENCODER_Valid_In     (vin),
        .INS_ENCODER_Ready_Out    (rdy_out),
        .INS_ENCODER_Fmt_InBUS    (fmt),
        .INS_ENCODER_Opcode_InBUS (op),
        .INS_ENCODER_Funct3_InBUS (f3),
        .INS_ENCODER_Rd_InBUS     (rd),
        .INS_ENCODER_Rs1_InBUS    (rs1),
        .INS_ENCODER_Rs2_InBUS    (rs2),
        .INS_ENCODER_Imm_InBUS    (imm),
        .INS_ENCODER_Valid_Out    (vout),
        .INS_ENCODER_Ready_In     (rdy_in),
        .INS_ENCODER_ins_OutBUS   (word),
        .INS_ENCODER_Err_Out      (err),
        .INS_ENCODER_ErrClr_In    (eclr),
        .INS_ENCODER_Count_OutBUS (cnt)
    );

    // Field placement expressed as shift-and-mask arithmetic on the instruction bit positions.
    function automatic logic [31:0] model_enc(int f, logic [6:0] o, logic [2:0] fn3,
                                              logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                              logic [31:0] i);
        logic [31:0] base;
        logic [31:0] regs;
        base = 32'(o);
        regs = (32'(fn3) << 12) | (32'(s1) << 15) | (32'(s2) << 20);
        case (f)
            0: return base | (32'(d) << 7) | (32'(fn3) << 12) | (32'(s1) << 15) | ((i & 32'hFFF) << 20);
            1: return base | regs | ((i & 32'h1F) << 7) | (((i >> 5) & 32'h7F) << 25);
            2: return base | regs | (((i >> 11) & 1) << 7) | (((i >> 1) & 32'hF) << 8)
                      | (((i >> 5) & 32'h3F) << 25) | (((i >> 12) & 1) << 31);
            3: return base | (32'(d) << 7) | (i & 32'hFFFFF000);
            4: return base | (32'(d) << 7) | (((i >> 12) & 32'hFF) << 12) | (((i >> 11) & 1) << 20)
                      | (((i >> 1) & 32'h3FF) << 21) | (((i >> 20) & 1) << 31);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_range_bad(int f, logic [31:0] i);
`ifdef INS_ENCODER_RANGECHK_EN
        int s;
        s = $signed(i);
        case (f)
            0, 1:    return (s < -2048) || (s > 2047);
            2:       return (s < -4096) || (s > 4094) || i[0];
            3:       return (i % 4096) != 0;
            4:       return (s < -1048576) || (s > 1048574) || i[0];
            default: return 1'b0;
        endcase
`else
        return (f < 0) && (i == 32'h0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int exp_cnt;
        exp_cnt = (m_pushes > CNT_MAX) ? CNT_MAX : m_pushes;
        chk("ready_out", 32'(rdy_out), 32'(q.size() < DEPTH));
        chk("valid_out", 32'(vout), 32'(q.size() != 0));
        chk("ins_out", word, (q.size() != 0) ? q[0] : 32'h0);
        chk("err_out", 32'(err), 32'(m_err));
        chk("count", 32'(cnt), 32'(exp_cnt));
    endtask

    // Checks the settled state, advances one clock, then applies the same edge to the model.
    task automatic step();
        bit acc;
        bit pp;
        bit set_err;
        logic [31:0] dropped;
        #1;
        check_state();
        acc = 1'b0;
        if (rst) begin
            q.delete();
            m_err = 1'b0;
            m_pushes = 0;
        end else begin
            acc = vin && (q.size() < DEPTH);
            pp  = (q.size() != 0) && rdy_in;
            set_err = acc && ((fmt > 4) || model_range_bad(int'(fmt), imm));
            if (pp) dropped = q.pop_front();
            if (acc && fmt <= 4) begin
                q.push_back(model_enc(int'(fmt), op, f3, rd, rs1, rs2, imm));
                m_pushes++;
            end
            if (set_err) m_err = 1'b1;
            else if (eclr) m_err = 1'b0;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] o, input logic [2:0] fn3,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] i);
        vin = 1'b1; fmt = f; op = o; f3 = fn3; rd = d; rs1 = s1; rs2 = s2; imm = i;
    endtask

    task automatic rand_req();
        logic [31:0] i;
        case ($urandom_range(0, 3))
            0: i = 32'($urandom_range(0, 8191)) - 32'd4096;
            1: i = $urandom;
            2: i = $urandom & 32'hFFFFF000;
            default: i = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFFFFFE;
        endcase
        drive(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), i);
        vin = 1'($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; rdy_in = 1'b0; eclr = 1'b0;
        fmt = '0; op = '0; f3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        q.delete(); m_err = 1'b0; m_pushes = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", 32'(rdy_out), 32'h1);
        chk("reset_valid", 32'(vout), 32'h0);
        chk("reset_word", word, 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_count", 32'(cnt), 32'h0);

        // Canonical I-type, latency 1
        drive(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        vin = 1'b0;
        chk("i_addi_word", word, 32'h00500093);
        chk("i_addi_count", 32'(cnt), 32'd1);
        rdy_in = 1'b1;
        step();

        // B, U, J reference words
        rdy_in = 1'b0;
        drive(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
        step(); vin = 1'b0;
        chk("b_word", word, 32'hFE000EE3);
        rdy_in = 1'b1; step(); rdy_in = 1'b0;
        drive(3'd3, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345000);
        step(); vin = 1'b0;
        chk("u_word", word, 32'h123450B7);
        rdy_in = 1'b1; step(); rdy_in = 1'b0;
        drive(3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        step(); vin = 1'b0;
        chk("j_word", word, 32'h0000006F);
        rdy_in = 1'b1; step(); rdy_in = 1'b0;

        // Fill to full with the fifth request held, then drain
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(3'd0, 7'h13, 3'd0, 5'(k + 1), 5'd2, 5'd0, 32'(k * 3));
            step();
        end
        drive(3'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd4, 32'h7F0);
        step();
        chk("full_ready_low", 32'(rdy_out), 32'h0);
        step();
        rdy_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (last_acc) break;
        end
        chk("fifth_accepted", 32'(last_acc), 32'h1);
        vin = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("drain_count", 32'(cnt), 32'd5);

        // Invalid format, then clear
        drive(3'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        step(); vin = 1'b0;
        chk("invalid_err", 32'(err), 32'h1);
        chk("invalid_nopush", 32'(vout), 32'h0);
        chk("invalid_count", 32'(cnt), 32'd5);
        eclr = 1'b1; step(); eclr = 1'b0;
        chk("errclr", 32'(err), 32'h0);

        // Set beats clear in the same cycle
        drive(3'd7, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        eclr = 1'b1; step(); eclr = 1'b0; vin = 1'b0;
        chk("set_wins", 32'(err), 32'h1);
        eclr = 1'b1; step(); eclr = 1'b0;

        // Out-of-range I immediate still pushes the truncated word
        rdy_in = 1'b0;
        drive(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        step(); vin = 1'b0;
        chk("range_word", word, 32'h80000093);
`ifdef INS_ENCODER_RANGECHK_EN
        chk("range_err", 32'(err), 32'h1);
`else
        chk("range_err", 32'(err), 32'h0);
`endif
        rdy_in = 1'b1; eclr = 1'b1; step(); eclr = 1'b0;

        // Reset with three words queued
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(3'd3, 7'h17, 3'd0, 5'(k + 7), 5'd0, 5'd0, 32'hABC00000 + 32'(k << 12));
            step();
        end
        vin = 1'b1;
        rst = 1'b1; step(); rst = 1'b0; vin = 1'b0;
        chk("rst_valid", 32'(vout), 32'h0);
        chk("rst_count", 32'(cnt), 32'h0);
        rdy_in = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Counter saturation
        for (int k = 0; k < CNT_MAX + 5; k++) begin
            drive(3'($urandom_range(0, 4)), 7'($urandom), 3'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), $urandom & 32'h7FE);
            step();
        end
        vin = 1'b0;
        chk("count_sat", 32'(cnt), 32'(CNT_MAX));
        do_reset();

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            rand_req();
            rdy_in = 1'($urandom_range(0, 2) != 0);
            eclr   = 1'($urandom_range(0, 7) == 0);
            rst    = 1'($urandom_range(0, 60) == 0);
            step();
        end
        rst = 1'b0; vin = 1'b0; eclr = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
